// File: rtl/pe_pkg.sv
// Shared PE constants and types used by the filter scratchpad write and read address generators.
package pe_pkg;

   localparam int FILTER_SPAD_DEPTH         = 225;
   localparam int CONFIG_BIT                = 5;
   localparam int DATA_WIDTH                = 16;
   localparam int FILTER_SPAD_ADDRESS_WIDTH = $clog2(FILTER_SPAD_DEPTH);
   localparam int CFG_PROD_WIDTH            = 2 * CONFIG_BIT;

   typedef logic [CFG_PROD_WIDTH-1:0] cfg_prod_t;

   localparam cfg_prod_t                SPAD_DEPTH_PROD = cfg_prod_t'(FILTER_SPAD_DEPTH);
   localparam logic [CONFIG_BIT-1:0]    CFG_ZERO        = {CONFIG_BIT{1'b0}};
   localparam logic [CONFIG_BIT-1:0]    CFG_ONE         = {{(CONFIG_BIT-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } filter_wr_state_t;

   // Full-width product so a large size*count can never wrap below the depth.
   function automatic cfg_prod_t cfg_product(input logic [CONFIG_BIT-1:0] size,
                                             input logic [CONFIG_BIT-1:0] count);
      return cfg_prod_t'(size) * cfg_prod_t'(count);
   endfunction

endpackage

// File: rtl/filter_spad_writer_if.sv
// Weight stream handshake plus filter spad write port between the PE input FIFO and the spad.
interface filter_spad_writer_if;
   import pe_pkg::*;

   logic [DATA_WIDTH-1:0]                in_data;
   logic                                 in_valid;
   logic                                 in_ready;
   logic                                 wr_en;
   logic [FILTER_SPAD_ADDRESS_WIDTH-1:0] wr_address;
   logic [DATA_WIDTH-1:0]                wr_data;

   modport master (
      output in_data, in_valid,
      input  in_ready, wr_en, wr_address, wr_data
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, wr_en, wr_address, wr_data
   );

endinterface

// File: rtl/Adder.sv
// Plain unsigned adder, wrap-around at WIDTH bits.
module Adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o
);

   assign sum_o = a_i + b_i;

endmodule

// File: rtl/filter_wr_counter.sv
// Offset/base counter pair for the filter spad writer: offset walks a filter, base jumps by the filter size.
module filter_wr_counter import pe_pkg::*; (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clr_i,
   input  logic                                 adv_i,
   input  logic [CONFIG_BIT-1:0]                size_i,
   output logic [FILTER_SPAD_ADDRESS_WIDTH-1:0] base_o,
   output logic [FILTER_SPAD_ADDRESS_WIDTH-1:0] addr_o,
   output logic                                 last_o
);

   localparam int AW = FILTER_SPAD_ADDRESS_WIDTH;

   logic [CONFIG_BIT-1:0] offset_q, offset_d;
   logic [AW-1:0]         base_q, base_d;
   logic [AW-1:0]         offset_ext_s;
   logic [AW-1:0]         size_ext_s;
   logic [AW-1:0]         base_next_s;

   assign offset_ext_s = {{(AW-CONFIG_BIT){1'b0}}, offset_q};
   assign size_ext_s   = {{(AW-CONFIG_BIT){1'b0}}, size_i};
   assign last_o       = (offset_q == (size_i - CFG_ONE));
   assign base_o       = base_q;

   Adder #(.WIDTH(AW)) u_addr_add (.a_i(base_q), .b_i(offset_ext_s), .sum_o(addr_o));
   Adder #(.WIDTH(AW)) u_base_add (.a_i(base_q), .b_i(size_ext_s),   .sum_o(base_next_s));

   always_comb begin
      offset_d = offset_q;
      base_d   = base_q;
      if (clr_i) begin
         offset_d = CFG_ZERO;
         base_d   = {AW{1'b0}};
      end else if (adv_i) begin
         if (last_o) begin
            offset_d = CFG_ZERO;
            base_d   = base_next_s;
         end else begin
            offset_d = offset_q + CFG_ONE;
         end
      end else begin
         offset_d = offset_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         offset_q <= CFG_ZERO;
         base_q   <= {AW{1'b0}};
      end else begin
         offset_q <= offset_d;
         base_q   <= base_d;
      end
   end

endmodule

// File: rtl/filter_spad_writer.sv
// Loads a weight stream into the filter spad as contiguous filter_size-word filters from address 0
// and reports per-filter and whole-load completion.
module filter_spad_writer import pe_pkg::*; (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic                                 clear,
   input  logic [CONFIG_BIT-1:0]                filter_size,
   input  logic [CONFIG_BIT-1:0]                filter_count,
   filter_spad_writer_if.slave                  bus,
   output logic [FILTER_SPAD_ADDRESS_WIDTH-1:0] filter_base_address,
   output logic [CONFIG_BIT-1:0]                filters_loaded,
   output logic                                 filter_done,
   output logic                                 load_done,
   output logic                                 overflow_err
);

   filter_wr_state_t      state_q, state_d;
   logic [CONFIG_BIT-1:0] size_q, size_d;
   logic [CONFIG_BIT-1:0] count_q, count_d;
   logic [CONFIG_BIT-1:0] loaded_q, loaded_d;
   logic                  filter_done_q, filter_done_d;

   logic in_ready_s, wr_en_s, launch_s, last_word_s, last_filter_s, filter_end_s;
   logic cfg_zero_s, cfg_too_big_s;
   logic [FILTER_SPAD_ADDRESS_WIDTH-1:0] wr_address_s;

   assign cfg_zero_s    = (filter_size == CFG_ZERO) || (filter_count == CFG_ZERO);
   assign cfg_too_big_s = (cfg_product(filter_size, filter_count) > SPAD_DEPTH_PROD);
   // clear masks both a new launch and the write strobe in the same cycle
   assign launch_s      = start && !clear && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign wr_en_s       = bus.in_valid && in_ready_s && !clear;
   assign last_filter_s = (loaded_q == (count_q - CFG_ONE));
   assign filter_end_s  = wr_en_s && last_word_s;

   filter_wr_counter u_counter (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (clear || launch_s),
      .adv_i  (wr_en_s),
      .size_i (size_q),
      .base_o (filter_base_address),
      .addr_o (wr_address_s),
      .last_o (last_word_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  if (cfg_zero_s)         state_d = ST_DONE;
                  else if (cfg_too_big_s) state_d = ST_ERR;
                  else                    state_d = ST_LOAD;
               end else begin
                  state_d = state_q;
               end
            end
            ST_LOAD: begin
               if (filter_end_s && last_filter_s) state_d = ST_DONE;
               else                               state_d = ST_LOAD;
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready_s   = 1'b0;
      load_done    = 1'b0;
      overflow_err = 1'b0;
      case (state_q)
         ST_LOAD: in_ready_s   = 1'b1;
         ST_DONE: load_done    = 1'b1;
         ST_ERR:  overflow_err = 1'b1;
         default: in_ready_s   = 1'b0;
      endcase
   end

   always_comb begin
      size_d        = size_q;
      count_d       = count_q;
      loaded_d      = loaded_q;
      filter_done_d = filter_end_s;
      if (clear) begin
         size_d   = CFG_ZERO;
         count_d  = CFG_ZERO;
         loaded_d = CFG_ZERO;
      end else if (launch_s) begin
         size_d   = filter_size;
         count_d  = filter_count;
         loaded_d = CFG_ZERO;
      end else if (filter_end_s) begin
         loaded_d = loaded_q + CFG_ONE;
      end else begin
         loaded_d = loaded_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         size_q        <= CFG_ZERO;
         count_q       <= CFG_ZERO;
         loaded_q      <= CFG_ZERO;
         filter_done_q <= 1'b0;
      end else begin
         size_q        <= size_d;
         count_q       <= count_d;
         loaded_q      <= loaded_d;
         filter_done_q <= filter_done_d;
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.wr_en      = wr_en_s;
   assign bus.wr_address = wr_address_s;
   assign bus.wr_data    = bus.in_data;
   assign filters_loaded = loaded_q;
   assign filter_done    = filter_done_q;

endmodule

// File: tb/tb_filter_spad_writer.sv
// Self-checking bench for filter_spad_writer: a word-count model checked every cycle plus directed literal checks.
module tb_filter_spad_writer;
   import pe_pkg::*;

   localparam int PH_IDLE = 0;
   localparam int PH_LOAD = 1;
   localparam int PH_DONE = 2;
   localparam int PH_ERR  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       clear = 1'b0;
   logic [4:0] filter_size = 5'd0;
   logic [4:0] filter_count = 5'd0;
   logic [7:0] filter_base_address;
   logic [4:0] filters_loaded;
   logic       filter_done, load_done, overflow_err;

   filter_spad_writer_if bus ();

   filter_spad_writer dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .clear               (clear),
      .filter_size         (filter_size),
      .filter_count        (filter_count),
      .bus                 (bus),
      .filter_base_address (filter_base_address),
      .filters_loaded      (filters_loaded),
      .filter_done         (filter_done),
      .load_done           (load_done),
      .overflow_err        (overflow_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int wlog[$];
   int fdone_cnt = 0;

   // model: the load is just a count of accepted words laid out linearly from address 0
   int m_phase = PH_IDLE;
   int m_words = 0;
   int m_size  = 0;
   int m_count = 0;
   int m_fdone = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = PH_IDLE;
      m_words = 0;
      m_size  = 0;
      m_count = 0;
      m_fdone = 0;
   endtask

   task automatic model_step();
      m_fdone = 0;
      if (clear) begin
         m_phase = PH_IDLE;
         m_words = 0;
         m_size  = 0;
         m_count = 0;
      end else if (m_phase == PH_IDLE || m_phase == PH_DONE) begin
         if (start) begin
            m_size  = int'(filter_size);
            m_count = int'(filter_count);
            m_words = 0;
            if (m_size == 0 || m_count == 0)          m_phase = PH_DONE;
            else if (m_size * m_count > 225)          m_phase = PH_ERR;
            else                                      m_phase = PH_LOAD;
         end
      end else if (m_phase == PH_LOAD) begin
         if (bus.in_valid) begin
            m_words++;
            if (m_words % m_size == 0)        m_fdone = 1;
            if (m_words == m_size * m_count)  m_phase = PH_DONE;
         end
      end
   endtask

   task automatic compare();
      int exp_ready, exp_wr, exp_loaded;
      exp_ready  = (m_phase == PH_LOAD) ? 1 : 0;
      exp_wr     = (exp_ready == 1 && bus.in_valid && !clear) ? 1 : 0;
      exp_loaded = (m_size > 0) ? m_words / m_size : 0;
      chk("in_ready",     int'(bus.in_ready),          exp_ready);
      chk("wr_en",        int'(bus.wr_en),             exp_wr);
      chk("wr_address",   int'(bus.wr_address),        m_words);
      chk("wr_data",      int'(bus.wr_data),           int'(bus.in_data));
      chk("filters_ld",   int'(filters_loaded),        exp_loaded);
      chk("base_addr",    int'(filter_base_address),   exp_loaded * m_size);
      chk("filter_done",  int'(filter_done),           m_fdone);
      chk("load_done",    int'(load_done),             (m_phase == PH_DONE) ? 1 : 0);
      chk("overflow_err", int'(overflow_err),          (m_phase == PH_ERR) ? 1 : 0);
      if (bus.wr_en)  wlog.push_back(int'(bus.wr_address));
      if (filter_done) fdone_cnt++;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_step();
         @(negedge clk);
         if (rst) model_reset();
         compare();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // config inputs are scrambled after start to show they are not re-sampled
   task automatic do_start(input int fs, input int fc);
      filter_size  = 5'(fs);
      filter_count = 5'(fc);
      start = 1'b1;
      tick();
      start = 1'b0;
      filter_size  = 5'd31;
      filter_count = 5'd31;
   endtask

   task automatic send(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'(32'h1000 + i * 7);
         tick();
         if (gap != 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 16'hDEAD;
            tick();
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic check_log(input string name, input int n);
      chk({name, "_count"}, wlog.size(), n);
      for (int i = 0; i < n && i < wlog.size(); i++)
         chk({name, "_addr"}, wlog[i], i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 16'h0000;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_wr_addr",  int'(bus.wr_address), 0);
      chk("rst_loaded",   int'(filters_loaded), 0);
      chk("rst_load_done", int'(load_done), 0);
      tick();

      // basic load 3x2
      wlog.delete(); fdone_cnt = 0;
      do_start(3, 2);
      chk("basic_ready", int'(bus.in_ready), 1);
      send(6, 0);
      chk("basic_fdone_last", int'(filter_done), 1);
      chk("basic_load_done",  int'(load_done), 1);
      chk("basic_loaded",     int'(filters_loaded), 2);
      tick();
      chk("basic_fdone_cnt", fdone_cnt, 2);
      check_log("basic", 6);

      // backpressure gaps, then valid held in DONE
      wlog.delete();
      do_start(3, 2);
      send(6, 1);
      bus.in_valid = 1'b1;
      repeat (3) tick();
      bus.in_valid = 1'b0;
      check_log("gaps", 6);
      chk("gaps_load_done", int'(load_done), 1);
      chk("gaps_loaded", int'(filters_loaded), 2);

      // overflow 25x10
      wlog.delete();
      do_start(25, 10);
      chk("ovf_err", int'(overflow_err), 1);
      bus.in_valid = 1'b1;
      repeat (3) tick();
      chk("ovf_ready", int'(bus.in_ready), 0);
      chk("ovf_nowrite", wlog.size(), 0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      bus.in_valid = 1'b0;
      chk("ovf_clr_err", int'(overflow_err), 0);
      chk("ovf_clr_done", int'(load_done), 0);
      chk("ovf_clr_base", int'(filter_base_address), 0);

      // exact capacity 15x15
      wlog.delete(); fdone_cnt = 0;
      do_start(15, 15);
      send(225, 0);
      chk("cap_load_done", int'(load_done), 1);
      chk("cap_err", int'(overflow_err), 0);
      tick();
      check_log("cap", 225);
      chk("cap_fdone_cnt", fdone_cnt, 15);
      chk("cap_loaded", int'(filters_loaded), 15);

      // clear with the 6th accept of a 4x2 load
      wlog.delete();
      do_start(4, 2);
      send(5, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0BAD;
      clear = 1'b1;
      #1 chk("clr_wr_en", int'(bus.wr_en), 0);
      tick();
      clear = 1'b0;
      bus.in_valid = 1'b0;
      chk("clr_ready", int'(bus.in_ready), 0);
      chk("clr_loaded", int'(filters_loaded), 0);
      check_log("clr_pre", 5);
      wlog.delete();
      do_start(4, 2);
      send(8, 0);
      check_log("clr_fresh", 8);
      chk("clr_fresh_done", int'(load_done), 1);

      // zero count, then restart from DONE with 2x1
      wlog.delete();
      do_start(2, 0);
      chk("zero_done", int'(load_done), 1);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("zero_nowrite", wlog.size(), 0);
      do_start(2, 1);
      send(2, 0);
      check_log("restart", 2);
      chk("restart_loaded", int'(filters_loaded), 1);

      // async reset in the middle of a load
      do_start(3, 2);
      send(2, 0);
      bus.in_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("arst_ready",  int'(bus.in_ready), 0);
      chk("arst_wr_en",  int'(bus.wr_en), 0);
      chk("arst_addr",   int'(bus.wr_address), 0);
      chk("arst_loaded", int'(filters_loaded), 0);
      chk("arst_base",   int'(filter_base_address), 0);
      tick();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      chk("arst_after_ready", int'(bus.in_ready), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/filter_spad_writer.md
# filter_spad_writer

Write-side address generator and loader for the PE filter scratchpad. Accepts a stream of filter weights over a valid/ready handshake and writes them into the filter spad as contiguous filters of `filter_size` words, starting at address 0. The filter read address generator reads the same layout, where filter k starts at k·filter_size. Sits between the PE input FIFO and the filter spad write port, and reports per-filter and whole-load completion to the PE controller.

## Interface
- `FILTER_SPAD_DEPTH`, 225: spad words.
- `CONFIG_BIT`, 5: width of the config inputs.
- `DATA_WIDTH`, 16: weight width.
- `FILTER_SPAD_ADDRESS_WIDTH`, $clog2(FILTER_SPAD_DEPTH): spad address width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a load; `filter_size` and `filter_count` are sampled on this cycle.
- `clear`  in  1  synchronous abort; returns the block to IDLE.
- `filter_size`  in  CONFIG_BIT  words per filter.
- `filter_count`  in  CONFIG_BIT  number of filters to load.
- `in_data`  in  DATA_WIDTH  incoming weight.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word.
- `wr_en`  out  1  spad write strobe.
- `wr_address`  out  FILTER_SPAD_ADDRESS_WIDTH  spad write address.
- `wr_data`  out  DATA_WIDTH  spad write data.
- `filter_base_address`  out  FILTER_SPAD_ADDRESS_WIDTH  base address of the filter currently being written.
- `filters_loaded`  out  CONFIG_BIT  number of completed filters.
- `filter_done`  out  1  one-cycle pulse after each filter completes.
- `load_done`  out  1  high while in DONE.
- `overflow_err`  out  1  high while in ERR.

## Operation
- **FSM states:** IDLE, LOAD, DONE, ERR.
- **Registered state:** `size_r`, `count_r`, `base` (addr width), `offset` (CONFIG_BIT), `filters_loaded`.
- **IDLE:** `in_ready`=0.
  - On `start`, latch the config and clear `base`, `offset` and `filters_loaded`.
  - If `filter_size`==0 or `filter_count`==0, go to DONE.
  - Else if `filter_size`·`filter_count` > `FILTER_SPAD_DEPTH`, go to ERR. The product is computed at 2·CONFIG_BIT width, with no truncation.
  - Else go to LOAD.
- **LOAD:** `in_ready`=1.
  - A word is accepted when `in_valid`&`in_ready`.
  - `wr_en` = accept, combinational.
  - `wr_address` = `base`+`offset`, computed at address width.
  - `wr_data` = `in_data`.
- **On accept, not the last word of a filter:** `offset`++.
- **On accept, last word of a filter** (`offset`==`size_r`−1):
  - `offset`←0, `base`←`base`+`size_r`, `filters_loaded`++.
  - `filter_done` pulses on the next cycle.
  - If this filter was the last one (`filters_loaded`==`count_r`−1), go to DONE.
- **DONE:** `in_ready`=0 and `load_done`=1. `start` begins a new load, with the same checks as IDLE. `filters_loaded` holds until then.
- **ERR:** `in_ready`=0 and `overflow_err`=1. Only `clear` or `rst` exits.
- **`start` in LOAD:** ignored.
- **`clear`:**
  - Wins over `start` and over an accept in the same cycle.
  - That cycle's `wr_en` is forced to 0.
  - Next state is IDLE, with all counters zeroed.
- **Input changes:** changes to `filter_size` or `filter_count` after `start` have no effect.

## Timing
- **Reset values:** state=IDLE; `in_ready`, `wr_en`, `filter_done`, `load_done`, `overflow_err` = 0; `wr_address`, `filter_base_address`, `filters_loaded` = 0; `wr_data` = `in_data`, which is passed through.
- **Write latency:** zero. The write strobe, address and data appear in the accept cycle, and the spad samples them on the same edge.
- **State transitions:** `start`→LOAD takes 1 cycle, so `in_ready` rises on the cycle after `start`.
- **Throughput:** 1 word per cycle. Back-to-back filters need no bubble.
- **Completion signals:** `filter_done` is registered and arrives 1 cycle after the accept of the last word. `load_done` rises in the same cycle as the final `filter_done`.
- **`rst`:** takes effect immediately at any point, including mid-load. `clear` takes effect at the next edge.

## Structure
- **Shared package `pe_pkg`:**
  - FSM state typedef `filter_wr_state_t` (IDLE/LOAD/DONE/ERR).
  - `FILTER_SPAD_DEPTH`, `CONFIG_BIT` and the address-width constants, shared with the filter read generator.
- **Sub-module:** one, `filter_wr_counter`. It holds the `offset`/`base` counter pair, with last-word detect and base advance.
  - FSM and handshake logic stay in the top module.
- **Reuse:** the existing `Adder` for `base`+`offset` and `base`+`size_r`.

## Test plan
- **Basic load:** `filter_size`=3, `filter_count`=2, words 1..6 with continuous valid → `wr_address` 0,1,2,3,4,5. `filter_done` pulses after words 3 and 6. `load_done`=1 in the same cycle as the second pulse. `filters_loaded`=2.
- **Backpressure gaps:** same config, `in_valid` toggling 1,0,1,0 → writes occur only on valid cycles, the address sequence is unchanged, and no write happens in DONE even with `in_valid`=1.
- **Overflow:** `filter_size`=25, `filter_count`=10 (250 > 225) → ERR, `overflow_err`=1, `in_ready` stays 0. After `clear`, next cycle: IDLE, all outputs 0.
- **Exact capacity:** `filter_size`=15, `filter_count`=15 (225) → the final write is at address 224, followed by `load_done`, with no error.
- **Clear mid-filter:** `filter_size`=4, `filter_count`=2, `clear` asserted together with the 6th accept → `wr_en`=0 that cycle, then IDLE with `filters_loaded`=0. A fresh `start` then writes from address 0.
- **Zero config and restart:** `filter_count`=0 → DONE the next cycle, with zero writes. A second `start` from DONE with `filter_size`=2, `filter_count`=1 → addresses 0,1.
- **Async reset mid-load:** `rst` asserted during LOAD → all outputs 0 immediately.
